// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. ADD/SUB/shifts complete in one cycle, and MUL runs on an iterative
// shift-add engine. Define ALU_DIV_EN to add a signed restoring divider for DIV/REM. Without
// it, codes 1000/1001 are reported as illegal.
module alu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ctr,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             illegal
);

   localparam int unsigned    SHW     = $clog2(WIDTH);
   localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

   localparam logic [3:0] OpAdd = 4'b0000;
   localparam logic [3:0] OpSub = 4'b0001;
   localparam logic [3:0] OpMul = 4'b0010;
   localparam logic [3:0] OpSll = 4'b0100;
   localparam logic [3:0] OpSrl = 4'b0101;
   localparam logic [3:0] OpSra = 4'b0110;
`ifdef ALU_DIV_EN
   localparam logic [3:0] OpDiv = 4'b1000;
   localparam logic [3:0] OpRem = 4'b1001;
`endif

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q, state_d;
   logic [SHW-1:0]   cnt_q;
   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
   logic [WIDTH-1:0] out_q;
   logic             illegal_q;

   logic             hs;
   logic             busy;
   logic             cnt_last;
   logic             cnt_en;
   logic             is_div;
   logic             div_fix;
   logic             mul_fin;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] single_res;
   logic             single_ill;
   logic             multi;
   logic [SHW-1:0]   sh;

`ifdef ALU_DIV_EN
   logic             op_div_q, op_rem_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvsr_q, a_q;
   logic             neg_quo_q, neg_rem_q, bzero_q, fix_q;
   logic [WIDTH:0]   rem_sh, diff;
   logic [WIDTH-1:0] rem_nxt, quo_nxt, div_res;
`endif

   assign hs       = in_valid && (state_q == StIdle);
   assign busy     = (state_q == StBusy);
   assign cnt_last = (cnt_q == CntLast);
   assign sh       = b[SHW-1:0];

`ifdef ALU_DIV_EN
   assign is_div  = op_div_q;
   assign div_fix = busy && op_div_q && fix_q;
`else
   assign is_div  = 1'b0;
   assign div_fix = 1'b0;
`endif

   assign mul_fin = busy && !is_div && cnt_last;
   // The sign-fix cycle of the divider does not advance the bit counter
   assign cnt_en  = busy && !div_fix;

   // Decode the request: single-cycle result, illegal flag, or multi-cycle engine
   always_comb begin
      single_res = '0;
      single_ill = 1'b0;
      multi      = 1'b0;
      case (ctr)
         OpAdd: single_res = a + b;
         OpSub: single_res = a - b;
         OpMul: multi      = 1'b1;
         OpSll: single_res = a << sh;
         OpSrl: single_res = a >> sh;
         OpSra: single_res = $signed(a) >>> sh;
`ifdef ALU_DIV_EN
         OpDiv: multi      = 1'b1;
         OpRem: multi      = 1'b1;
`endif
         default: single_ill = 1'b1;
      endcase
   end

   // Shift-add step: add the shifted multiplicand when the current multiplier bit is set
   always_comb begin
      acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   end

`ifdef ALU_DIV_EN
   // Restoring division step on magnitudes; bit WIDTH of diff is the borrow
   always_comb begin
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, dvsr_q};
      if (!diff[WIDTH]) begin
         rem_nxt = diff[WIDTH-1:0];
         quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_nxt = rem_sh[WIDTH-1:0];
         quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
      end
   end

   // Sign fix and the divide-by-zero override applied on the final cycle
   always_comb begin
      if (bzero_q) begin
         div_res = op_rem_q ? a_q : '1;
      end else if (op_rem_q) begin
         div_res = neg_rem_q ? (-rem_q) : rem_q;
      end else begin
         div_res = neg_quo_q ? (-quo_q) : quo_q;
      end
   end
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d = multi ? StBusy : StDone;
            end
         end
         StBusy: begin
            if (mul_fin || div_fix) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs; the result itself comes straight from a register
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
      out       = out_q;
      illegal   = illegal_q;
   end

   // Iteration counter: cleared on accept, wraps back to zero after the last bit
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (hs) begin
         cnt_q <= '0;
      end else if (cnt_en) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Multiplier registers: load operands on accept, shift one bit per busy cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (hs) begin
         acc_q    <= '0;
         mcand_q  <= a;
         mplier_q <= b;
      end else if (busy && !is_div) begin
         acc_q    <= acc_nxt;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
      end
   end

`ifdef ALU_DIV_EN
   // Divider registers: capture magnitudes and signs on accept, then iterate
   always_ff @(posedge clk) begin
      if (rst) begin
         op_div_q  <= 1'b0;
         op_rem_q  <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         a_q       <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         bzero_q   <= 1'b0;
         fix_q     <= 1'b0;
      end else if (hs) begin
         op_div_q  <= (ctr == OpDiv) || (ctr == OpRem);
         op_rem_q  <= (ctr == OpRem);
         rem_q     <= '0;
         quo_q     <= a[WIDTH-1] ? (-a) : a;
         dvsr_q    <= b[WIDTH-1] ? (-b) : b;
         a_q       <= a;
         neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
         neg_rem_q <= a[WIDTH-1];
         bzero_q   <= (b == '0);
         fix_q     <= 1'b0;
      end else if (busy && op_div_q && !fix_q) begin
         rem_q <= rem_nxt;
         quo_q <= quo_nxt;
         if (cnt_last) begin
            fix_q <= 1'b1;
         end
      end else if (div_fix) begin
         fix_q <= 1'b0;
      end
   end
`endif

   // Result register: written on accept for single-cycle ops, at the end of MUL/DIV otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q     <= '0;
         illegal_q <= 1'b0;
      end else if (hs) begin
         illegal_q <= single_ill;
         if (!multi) begin
            out_q <= single_res;
         end
      end else if (mul_fin) begin
         out_q <= acc_nxt;
`ifdef ALU_DIV_EN
      end else if (div_fix) begin
         out_q <= div_res;
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed stimulus for alu_seq with a scoreboard of expected results.
// The divider cases follow ALU_DIV_EN, the same macro that configures the design.
module tb_alu_seq;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       ctr;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             illegal;

   int checks = 0;
   int errors = 0;

   // Each entry is {illegal, out}
   logic [WIDTH:0] sb_q[$];

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ctr       (ctr),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                        input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request in an idle cycle and let the handshake edge pass
   task automatic start(input logic [3:0] op, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] eo,
                        input logic ei, input bit push, input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      ctr      = op;
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      if (push) sb_q.push_back({ei, eo});
      step();
      in_valid = 1'b0;
   endtask

   // Cycles since the handshake edge until out_valid; bounded
   task automatic wait_valid(input int exp_lat, input string tag);
      int lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         step();
         lat++;
      end
      in_valid = 1'b0;
      check({tag, "_lat"}, lat, exp_lat);
   endtask

   // Compare the presented result against the oldest scoreboard entry
   task automatic take(input string tag);
      logic [WIDTH:0] e;
      check({tag, "_sb_nonempty"}, (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({tag, "_valid"}, out_valid, 1);
         check({tag, "_out"}, out, e[WIDTH-1:0]);
         check({tag, "_illegal"}, illegal, e[WIDTH]);
      end
   endtask

   task automatic run(input logic [3:0] op, input logic [WIDTH-1:0] va,
                      input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] eo,
                      input logic ei, input int lat, input string tag);
      start(op, va, vb, eo, ei, 1'b1, tag);
      wait_valid(lat, tag);
      check({tag, "_done_ready"}, in_ready, 0);
      take(tag);
      step();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ctr       = 4'b0000;
      a         = '0;
      b         = '0;
      step();
      step();
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 0);
      check("rst_illegal", illegal, 0);

      // ADD wraps to zero; one-cycle latency, in_ready low while result is shown
      run(4'b0000, 32'h7fffffff, 32'h80000001, 32'h00000000, 1'b0, 1, "add_wrap");
      check("add_ready_after", in_ready, 1);

      // MUL with a competing request held during BUSY
      start(4'b0010, 32'hfffffffb, 32'h00000005, 32'hffffffe7, 1'b0, 1'b1, "mul");
      ctr      = 4'b0000;
      a        = 32'h11111111;
      b        = 32'h22222222;
      in_valid = 1'b1;
      check("mul_busy_ready", in_ready, 0);
      wait_valid(33, "mul");
      take("mul");
      step();
      check("mul_no_second_valid", out_valid, 0);
      check("mul_no_second_ready", in_ready, 1);

      // Shifts use only the low SHW bits of b
      run(4'b0110, 32'h80000000, 32'h0000001e, 32'hfffffffe, 1'b0, 1, "sra");
      run(4'b0100, 32'h00000001, 32'hffffffff, 32'h80000000, 1'b0, 1, "sll31");
      run(4'b0101, 32'hffffffff, 32'h00000020, 32'hffffffff, 1'b0, 1, "srl0");
      run(4'b0010, 32'h00012345, 32'hfffffffe, 32'hfffdb976, 1'b0, 33, "mul_neg");

      // Back-pressure: result held stable while out_ready is low
      out_ready = 1'b0;
      start(4'b0001, 32'h00000001, 32'h00000002, 32'hffffffff, 1'b0, 1'b1, "sub_bp");
      wait_valid(1, "sub_bp");
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", out_valid, 1);
         check("bp_out", out, 32'hffffffff);
         check("bp_ready", in_ready, 0);
         step();
      end
      out_ready = 1'b1;
      take("sub_bp");
      step();
      check("bp_release_ready", in_ready, 1);
      check("bp_release_valid", out_valid, 0);

      // Reset 10 cycles into a MUL discards it
      start(4'b0010, 32'h00000003, 32'h00000007, 32'h0, 1'b0, 1'b0, "mul_rst");
      for (int i = 0; i < 9; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out", out, 0);
      run(4'b0000, 32'h00000002, 32'hffffffff, 32'h00000001, 1'b0, 1, "add_after_rst");

      // Unsupported codes
      run(4'b0011, 32'h12345678, 32'h9abcdef0, 32'h00000000, 1'b1, 1, "ill_0011");
      run(4'b1111, 32'hffffffff, 32'hffffffff, 32'h00000000, 1'b1, 1, "ill_1111");

`ifdef ALU_DIV_EN
      run(4'b1000, 32'hfffffff9, 32'h00000002, 32'hfffffffd, 1'b0, 34, "div_neg");
      run(4'b1001, 32'hfffffff9, 32'h00000002, 32'hffffffff, 1'b0, 34, "rem_neg");
      run(4'b1000, 32'h00000005, 32'h00000000, 32'hffffffff, 1'b0, 34, "div_zero");
      run(4'b1001, 32'hfffffff9, 32'h00000000, 32'hfffffff9, 1'b0, 34, "rem_zero");
      run(4'b1000, 32'h80000000, 32'hffffffff, 32'h80000000, 1'b0, 34, "div_ovf");
      run(4'b1001, 32'h80000000, 32'hffffffff, 32'h00000000, 1'b0, 34, "rem_ovf");
      run(4'b1000, 32'h00000064, 32'hfffffff9, 32'hfffffff2, 1'b0, 34, "div_pos_neg");
`else
      run(4'b1000, 32'hfffffff9, 32'h00000002, 32'h00000000, 1'b1, 1, "div_absent");
      run(4'b1001, 32'hfffffff9, 32'h00000002, 32'h00000000, 1'b1, 1, "rem_absent");
`endif

      // After an illegal code, a legal op clears the flag
      run(4'b0000, 32'h00000005, 32'h00000006, 32'h0000000b, 1'b0, 1, "add_clear");

      check("sb_drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational 32-bit ALU. Operands are accepted over a valid/ready interface, and single-cycle operations complete in one cycle. MUL runs on an iterative shift-add engine, and DIV/REM use an optional restoring divider. The block sits between the issue stage and writeback of the core datapath, and back-pressure comes from the consumer.

## Interface
- WIDTH, 32, operand/result width in bits; minimum 8, power of two
- SHW, $clog2(WIDTH), shift-amount field width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- ctr  in  4  opcode
- a  in  WIDTH  operand A (signed)
- b  in  WIDTH  operand B (signed); shifts use b[SHW-1:0] only
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out  out  WIDTH  result
- illegal  out  1  qualifies out: unsupported opcode

## Operation
Opcodes:
- ADD 0000: a+b, wrapping
- SUB 0001: a-b, wrapping
- MUL 0010: low WIDTH bits of a*b (same for signed and unsigned)
- SLL 0100: logical left shift
- SRL 0101: logical right shift
- SRA 0110: arithmetic right shift
- DIV 1000 and REM 1001: available only with the divider (see Configuration)
- Any other code: out=0 and illegal=1, with single-cycle latency.

Shifts ignore b[WIDTH-1:SHW], so a shift amount of 0 passes a through unchanged.

FSM states:
- IDLE: in_ready=1. A handshake (in_valid&in_ready) latches ctr/a/b. Single-cycle ops and illegal codes go to DONE; MUL and DIV/REM go to BUSY.
- BUSY: in_ready=0. The iteration counter runs from 0 to WIDTH-1, processing one operand bit per cycle. When the count is exhausted the state moves to DONE (the divider first spends one extra sign-fix cycle).
- DONE: out_valid=1. out and illegal are held stable until out_ready=1, which returns the block to IDLE. out_valid is never withdrawn without a handshake.

Other rules:
- in_ready is low in BUSY and DONE. There is no bypass from DONE to IDLE acceptance in the same cycle.
- Operand or ctr changes while not in IDLE have no effect.
- Reset in any state, including mid-MUL/DIV, forces IDLE and discards the operation. Reset values: in_ready=1, out_valid=0, out=0, illegal=0, counter=0.

## Timing
- Latency is measured from the handshake edge to the first cycle with out_valid=1:
  - single-cycle ops and illegal codes: 1 cycle
  - MUL: WIDTH+1 cycles
  - DIV/REM: WIDTH+2 cycles
- Result ownership transfers on the edge where out_valid&out_ready. in_ready rises in the following cycle.
- Peak throughput with out_ready held high is one single-cycle op every 2 cycles.
- out is registered. There is no combinational path from in_* to out_*, and out_ready does not combinationally affect in_ready.

## Configuration
- ALU_DIV_EN defined: DIV and REM are implemented as signed restoring division on absolute values, followed by a sign fix.
  - Quotient truncates toward zero; the remainder takes the sign of a.
  - b=0: DIV returns all ones and REM returns a, with illegal=0.
  - a=most-negative and b=-1: DIV returns a and REM returns 0.
- ALU_DIV_EN undefined: the divider datapath is absent, and 1000/1001 behave like any other illegal code (out=0, illegal=1, latency 1).

## Test plan
1. Reset, then ADD with a=0x7fffffff, b=0x80000001 and out_ready=1 -> out=0x00000000, illegal=0, out_valid high exactly 1 cycle after the handshake, in_ready low during that cycle.
2. MUL with a=0xfffffffb, b=0x00000005 -> out=0xffffffe7 after 33 cycles. A second request during BUSY sees in_ready=0 and is not accepted.
3. Shift checks:
   - SRA with a=0x80000000, b=0x0000001e -> 0xfffffffe
   - SLL with a=1, b=0xffffffff (amount 31) -> 0x80000000
   - SRL with a=0xffffffff, b=0x20 (amount 0) -> 0xffffffff
4. Back-pressure: complete SUB with a=1, b=2 while holding out_ready=0 for 5 cycles -> out=0xffffffff stays stable with out_valid=1 throughout. Releasing out_ready gives in_ready=1 on the next cycle.
5. Assert rst for one cycle 10 cycles into a MUL -> next cycle in_ready=1, out_valid=0. A following ADD with a=2, b=0xffffffff returns 0x00000001.
6. Divider cases:
   - With ALU_DIV_EN: DIV with a=-7, b=2 -> 0xfffffffd; REM with the same operands -> 0xffffffff; DIV with b=0 -> 0xffffffff. Each takes 34 cycles.
   - Without ALU_DIV_EN: ctr=1000 -> out=0, illegal=1 after 1 cycle.
